// File: rtl/mul_cell_rr_sequencer_if.sv
// Request/response channels between requesters and the shared multiplier sequencer.
// Operands are packed flat: requester i occupies bits [32*i+31:32*i].
interface mul_cell_rr_sequencer_if #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*32-1:0] req_src1;
   logic [N_REQ*32-1:0] req_src2;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [ID_W-1:0]     rsp_id;
   logic [31:0]         rsp_result;

   modport master (
      output req_valid, req_src1, req_src2, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result
   );

   modport slave (
      input  req_valid, req_src1, req_src2, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result
   );
endinterface

// File: rtl/mul_cell_rr_sequencer.sv
// Round-robin sequencer sharing one registered 3-partial-product 16x16 multiplier cell
// among N_REQ requesters; returns the low 32 bits of src1*src2 with the requester id.
module mul_cell_rr_sequencer #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mul_cell_rr_sequencer_if.slave bus,
   output logic [31:0]            cell_src1,
   output logic [31:0]            cell_src2,
   output logic                   cell_en,
   input  logic [31:0]            cell_p1,
   input  logic [31:0]            cell_p2,
   input  logic [31:0]            cell_p3,
   output logic                   busy,
   output logic [CNT_W-1:0]       op_count
);
   localparam int PTR_W = $clog2(N_REQ);
   localparam int CW    = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]        src1_q, src1_d;
   logic [31:0]        src2_q, src2_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [31:0]        rsp_result_q, rsp_result_d;
   logic [CNT_W-1:0]   op_count_q, op_count_d;

   logic [31:0]        req_a [N_REQ];
   logic [31:0]        req_b [N_REQ];
   logic               grant_found;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   grant_next;
   logic [CW-1:0]      cand;
   logic               accept;
   logic [15:0]        cross_sum;
   logic [31:0]        product;
   logic               unused_hi;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign req_a[gi]         = bus.req_src1[32*gi +: 32];
         assign req_b[gi]         = bus.req_src2[32*gi +: 32];
         assign bus.req_ready[gi] = accept && (grant_idx == PTR_W'(gi));
      end
   endgenerate

   // Rotating priority search starting at the rr pointer, wrapping mod N_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + CW'(k);
         if (cand >= CW'(N_REQ)) begin
            cand = cand - CW'(N_REQ);
         end
         if (!grant_found && bus.req_valid[cand[PTR_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[PTR_W-1:0];
         end
      end
   end

   assign grant_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

   // Only the low halves of the cross products reach the low 32 result bits.
   assign cross_sum = cell_p2[15:0] + cell_p3[15:0];
   assign product   = cell_p1 + {cross_sum, 16'h0000};
   assign unused_hi = ^{cell_p2[31:16], cell_p3[31:16]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (grant_found) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_RESP;
         S_RESP:    if (bus.rsp_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are suppressed while reset is asserted.
   always_comb begin
      accept  = 1'b0;
      cell_en = 1'b0;
      busy    = (state_q != S_IDLE);
      if (reset_n) begin
         accept  = (state_q == S_IDLE) && grant_found;
         cell_en = (state_q == S_ISSUE);
      end
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      src1_d       = src1_q;
      src2_d       = src2_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      op_count_d   = op_count_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               src1_d   = req_a[grant_idx];
               src2_d   = req_b[grant_idx];
               id_d     = ID_W'(grant_idx);
               rr_ptr_d = grant_next;
            end
         end
         S_CAPTURE: begin
            rsp_result_d = product;
            rsp_id_d     = id_q;
            rsp_valid_d  = 1'b1;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr_q     <= '0;
         src1_q       <= '0;
         src2_q       <= '0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         op_count_q   <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         src1_q       <= src1_d;
         src2_q       <= src2_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         op_count_q   <= op_count_d;
      end
   end

   assign cell_src1      = src1_q;
   assign cell_src2      = src2_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign op_count       = op_count_q;
endmodule

// File: tb/tb_mul_cell_rr_sequencer.sv
// Directed bench for mul_cell_rr_sequencer with a behavioural multiplier cell and
// a result scoreboard fed on request accept and drained on response handshake.
module tb_mul_cell_rr_sequencer;
   localparam int N_REQ = 2;
   localparam int ID_W  = 1;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [31:0]       cell_src1, cell_src2;
   logic              cell_en;
   logic [31:0]       cell_p1, cell_p2, cell_p3;
   logic              busy;
   logic [CNT_W-1:0]  op_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     res;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   mul_cell_rr_sequencer_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus_if ();

   mul_cell_rr_sequencer #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus_if),
      .cell_src1 (cell_src1),
      .cell_src2 (cell_src2),
      .cell_en   (cell_en),
      .cell_p1   (cell_p1),
      .cell_p2   (cell_p2),
      .cell_p3   (cell_p3),
      .busy      (busy),
      .op_count  (op_count)
   );

   // Behavioural cell: partial products registered when enabled.
   always @(posedge clk) begin
      if (cell_en) begin
         cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
         cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
         cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
      end
   end

   function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] full;
      full = {32'h0, a} * {32'h0, b};
      return full[31:0];
   endfunction

   // Scoreboard: push on accept, pop and compare on response handshake.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (bus_if.req_valid[i] && bus_if.req_ready[i]) begin
               sb_q.push_back('{id: ID_W'(i),
                                res: model_mul(bus_if.req_src1[32*i +: 32], bus_if.req_src2[32*i +: 32])});
               $display("accept id=%0d a=%h b=%h", i, bus_if.req_src1[32*i +: 32], bus_if.req_src2[32*i +: 32]);
            end
         end
         if (bus_if.rsp_valid && bus_if.rsp_ready) begin
            $display("response id=%0d result=%h", bus_if.rsp_id, bus_if.rsp_result);
            check("sb_pending", 64'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_id", 64'(bus_if.rsp_id), 64'(e.id));
               check("sb_result", 64'(bus_if.rsp_result), 64'(e.res));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      while (bus_if.rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(tag, 64'(bus_if.rsp_valid), 1);
   endtask

   task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input string tag);
      int n;
      bus_if.req_src1[32*idx +: 32] = a;
      bus_if.req_src2[32*idx +: 32] = b;
      bus_if.req_valid[idx] = 1'b1;
      #1;
      n = 0;
      while (bus_if.req_ready[idx] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, 64'(bus_if.req_ready[idx]), 1);
      tick();
      bus_if.req_valid[idx] = 1'b0;
      wait_rsp({tag, "_rsp"});
      check({tag, "_result"}, 64'(bus_if.rsp_result), 64'(exp_res));
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ID_W-1:0] ids [4];
      logic [31:0]     held_res;
      logic [ID_W-1:0] held_id;
      int              got;

      cell_p1 = '0;
      cell_p2 = '0;
      cell_p3 = '0;
      reset_n = 1'b0;
      bus_if.req_valid = '1;
      bus_if.req_src1  = {32'hDEAD_0001, 32'h0001_0003};
      bus_if.req_src2  = {32'h0000_0007, 32'h0002_0005};
      bus_if.rsp_ready = 1'b0;

      // Reset with every requester asking.
      tick();
      tick();
      check("rst_req_ready", 64'(bus_if.req_ready), 0);
      check("rst_rsp_valid", 64'(bus_if.rsp_valid), 0);
      check("rst_cell_en", 64'(cell_en), 0);
      check("rst_op_count", 64'(op_count), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_cell_src1", 64'(cell_src1), 0);
      check("rst_rsp_result", 64'(bus_if.rsp_result), 0);

      // Single op on requester 0, step by step.
      reset_n = 1'b1;
      #1;
      check("first_grant", 64'(bus_if.req_ready), 64'(2'b01));
      tick();
      bus_if.req_valid = '0;
      check("iss_cell_en", 64'(cell_en), 1);
      check("iss_cell_src1", 64'(cell_src1), 64'(32'h0001_0003));
      check("iss_cell_src2", 64'(cell_src2), 64'(32'h0002_0005));
      check("iss_busy", 64'(busy), 1);
      tick();
      check("cap_cell_en", 64'(cell_en), 0);
      check("cap_rsp_valid", 64'(bus_if.rsp_valid), 0);
      tick();
      check("resp_valid", 64'(bus_if.rsp_valid), 1);
      check("resp_id", 64'(bus_if.rsp_id), 0);
      check("resp_result", 64'(bus_if.rsp_result), 64'(32'h000B_000F));
      check("resp_cell_en", 64'(cell_en), 0);
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
      check("single_op_count", 64'(op_count), 1);
      check("single_rsp_drop", 64'(bus_if.rsp_valid), 0);
      check("single_idle", 64'(busy), 0);

      // Wrap-around arithmetic.
      do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "wrap_ff");
      do_op(1, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "wrap_shift");
      check("wrap_op_count", 64'(op_count), 3);

      // Round-robin with both requesters held valid.
      bus_if.req_src1  = {32'h0003_0009, 32'h8000_0001};
      bus_if.req_src2  = {32'h0004_000B, 32'hC000_0003};
      bus_if.req_valid = 2'b11;
      bus_if.rsp_ready = 1'b1;
      got = 0;
      for (int n = 0; n < 60 && got < 4; n++) begin
         if (bus_if.rsp_valid === 1'b1) begin
            ids[got] = bus_if.rsp_id;
            got++;
         end
         tick();
      end
      bus_if.req_valid = '0;
      bus_if.rsp_ready = 1'b0;
      check("rr_count", 64'(got), 4);
      if (got == 4) begin
         check("rr_id0", 64'(ids[0]), 0);
         check("rr_id1", 64'(ids[1]), 1);
         check("rr_id2", 64'(ids[2]), 0);
         check("rr_id3", 64'(ids[3]), 1);
      end
      check("rr_op_count", 64'(op_count), 7);

      // Backpressure on a requester-1 response.
      bus_if.req_src1[63:32] = 32'hABCD_1234;
      bus_if.req_src2[63:32] = 32'h0F0F_F0F0;
      bus_if.req_valid = 2'b10;
      #1;
      check("bp_grant", 64'(bus_if.req_ready), 64'(2'b10));
      tick();
      bus_if.req_valid = 2'b01;
      wait_rsp("bp_rsp");
      held_res = bus_if.rsp_result;
      held_id  = bus_if.rsp_id;
      check("bp_result", 64'(held_res), 64'(model_mul(32'hABCD_1234, 32'h0F0F_F0F0)));
      check("bp_id", 64'(held_id), 1);
      for (int c = 0; c < 5; c++) begin
         tick();
         check("bp_valid_hold", 64'(bus_if.rsp_valid), 1);
         check("bp_result_hold", 64'(bus_if.rsp_result), 64'(held_res));
         check("bp_id_hold", 64'(bus_if.rsp_id), 64'(held_id));
         check("bp_req_ready", 64'(bus_if.req_ready), 0);
         check("bp_cell_en", 64'(cell_en), 0);
         check("bp_op_count", 64'(op_count), 7);
      end
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
      bus_if.req_valid = '0;
      check("bp_op_count_after", 64'(op_count), 8);

      // Reset asserted while in CAPTURE.
      bus_if.req_src1[31:0] = 32'h0000_0002;
      bus_if.req_src2[31:0] = 32'h0000_0003;
      bus_if.req_valid = 2'b01;
      #1;
      check("mr_grant", 64'(bus_if.req_ready), 64'(2'b01));
      tick();
      bus_if.req_valid = '0;
      tick();
      check("mr_in_capture", 64'(busy), 1);
      reset_n = 1'b0;
      sb_q.delete();
      tick();
      check("mr_rsp_valid", 64'(bus_if.rsp_valid), 0);
      check("mr_busy", 64'(busy), 0);
      check("mr_op_count", 64'(op_count), 0);
      bus_if.req_valid = 2'b11;
      #1;
      check("mr_no_ready_in_reset", 64'(bus_if.req_ready), 0);
      reset_n = 1'b1;
      #1;
      check("mr_ptr_zero", 64'(bus_if.req_ready), 64'(2'b01));
      tick();
      bus_if.req_valid = '0;
      wait_rsp("mr_post_rsp");
      check("mr_post_result", 64'(bus_if.rsp_result), 64'(32'h0000_0006));
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
      check("mr_post_op_count", 64'(op_count), 1);
      check("sb_drained", 64'(sb_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
